r2r_dac_wavegen: RTL and testbench
==================================

// Module: r2r_dac_wavegen
// PURPOSE
//   Parametrised digital controller for an N-bit R2R ladder DAC; successor to the 4-bit fixed controller.
//   Drives r2r_out with external data or an internally generated waveform.
//   Waveforms: ramp up, ramp down, triangle, square. Update rate is set by a programmable clock divider.
//   Sits between the tile digital I/O and the analog R2R macro.
// PARAMETERS
//   WIDTH      4   DAC resolution in bits (>=2); width of data and r2r_out
//   DIV_W      8   clock-divider register width (>=1)
//   DIV_RESET  9   divider value after reset (<2**DIV_W); 9 gives 10 MHz clk -> 1 MHz update rate
// PORTS
//   clk           in   1        system clock (10 MHz nominal)
//   rst           in   1        asynchronous, active-high reset
//   ext_data      in   1        1: DAC value taken from data; 0: internal waveform
//   mode          in   2        00 ramp up, 01 ramp down, 10 triangle, 11 square
//   data          in   WIDTH    external DAC value
//   load_divider  in   1        rising edge loads div_in into the divider
//   div_in        in   DIV_W    divider value to load
//   r2r_out       out  WIDTH    registered bits to the R2R ladder
//   tick          out  1        1-cycle pulse, high in the cycle r2r_out takes a new value
//   sync          out  1        1-cycle pulse with tick when the waveform restarts (phase==0)
// BEHAVIOUR
//   Clock and reset
//   - One clock. rst is asynchronous and active-high.
//   - Reset values: div_reg=DIV_RESET, cnt=DIV_RESET, phase=0, dir=up, mode_q=0, ld_q=0,
//     r2r_out=0, tick=0, sync=0. Takes effect immediately, including mid-waveform.
//   Divider
//   - cnt counts down every clk. When cnt==0 (update cycle), cnt reloads div_reg.
//   - Update period = div_reg+1 clks. div_reg=0 gives an update every clk.
//   - Load: ld_q registers load_divider. A rising edge (load_divider & !ld_q) sets div_reg<=div_in and cnt<=div_in.
//     The load overrides an update cycle in the same clk; that update is skipped.
//   - Holding load_divider high performs no further loads. The inputs are synchronous to clk.
//   Waveform state, advanced only on update cycles
//   - phase: WIDTH-bit counter, +1 per update, wraps from 2**WIDTH-1 to 0.
//   - ramp up r2r_out<=phase; ramp down r2r_out<=~phase.
//   - square: r2r_out<=phase[MSB] ? all-ones : 0, i.e. 2**(WIDTH-1) updates per level.
//   - triangle: tri value plus dir flag. Step +1 up to all-ones, then -1 down to 0, then up again.
//     Endpoints are not repeated: 14,15,14 ... 1,0,1. phase still counts for sync.
//   - Mode change: if mode!=mode_q in any clk, then phase<=0, tri<=0, dir<=up, mode_q<=mode.
//     The new waveform starts at the next update. r2r_out holds until then.
//   External data
//   - With ext_data=1, r2r_out<=data on each update cycle only. data changes between updates are not visible.
//   - phase/tri/dir freeze while ext_data=1 and resume from the frozen state when it returns to 0.
//   Outputs
//   - tick/sync are registered. tick=1 in the clk after an update cycle, coincident with the new r2r_out.
//   - sync=1 with tick when the phase used for that update was 0 and ext_data=0.
//   - Latency: update cycle -> r2r_out valid at the next clk edge (1 cycle).
//   - r2r_out changes only on update edges or reset. It is glitch-free (fully registered).
// TESTING
//   1 Reset with DIV_RESET=9, mode=00, ext_data=0 -> r2r_out=0, tick=0.
//     After release: first tick 10 clks later with r2r_out=0 and sync=1; next tick 10 clks later with r2r_out=1.
//   2 Load div_in=0 (edge), mode=00 -> r2r_out 0,1,...,15,0 on consecutive clks.
//     sync high on each 0. Ramp down gives 15,14,...,0.
//   3 div_in=1, mode=10 -> sequence 0,1,...,15,14,...,0,1, one step per 2 clks, no repeated endpoints.
//   4 div_in=0, mode=11 -> 8 clks at 0x0, 8 clks at 0xF, repeating.
//     Switching mode mid-level restarts at phase 0.
//   5 ext_data=1, data=0xA, div=3 -> r2r_out=0xA at next tick.
//     data=0x5 held for 2 clks between ticks -> not output.
//     ext_data=0 -> waveform resumes from the frozen value.
//   6 Mid-count load_divider edge with div_in=3 -> next tick exactly 4 clks after the load edge.
//     load_divider held high 20 clks -> period stays 4.
//     rst pulse mid-triangle -> r2r_out=0 asynchronously and dir=up.

Source files
------------

// File: rtl/r2r_dac_wavegen_if.sv
// r2r_dac_wavegen_if: control/data bundle between tile digital I/O and the
// R2R DAC controller.
//   ext_data      1: DAC value from data, 0: internal waveform
//   mode          00 ramp up, 01 ramp down, 10 triangle, 11 square
//   data          external DAC value
//   load_divider  rising edge loads div_in into the update-rate divider
//   div_in        divider value to load
//   r2r_out       registered bits to the R2R ladder
//   tick          1-cycle pulse when r2r_out takes a new value
//   sync          1-cycle pulse with tick when the waveform restarts
interface r2r_dac_wavegen_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DIV_W = 8
);
  logic             ext_data;
  logic [1:0]       mode;
  logic [WIDTH-1:0] data;
  logic             load_divider;
  logic [DIV_W-1:0] div_in;
  logic [WIDTH-1:0] r2r_out;
  logic             tick;
  logic             sync;

  modport master (
    output ext_data, mode, data, load_divider, div_in,
    input  r2r_out, tick, sync
  );

  modport slave (
    input  ext_data, mode, data, load_divider, div_in,
    output r2r_out, tick, sync
  );
endinterface

// File: rtl/r2r_dac_wavegen.sv
// r2r_dac_wavegen: parametrised controller for an N-bit R2R ladder DAC.
// Outputs either external data or an internal waveform (ramp up/down,
// triangle, square), updated once every div_reg+1 clocks.
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  r2r_dac_wavegen_if slave modport (controls in, r2r_out/tick/sync out)
module r2r_dac_wavegen #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned DIV_W     = 8,
  parameter int unsigned DIV_RESET = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  r2r_dac_wavegen_if.slave     bus
);

  typedef enum logic [1:0] {
    MODE_RAMP_UP = 2'b00,
    MODE_RAMP_DN = 2'b01,
    MODE_TRI     = 2'b10,
    MODE_SQUARE  = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  logic [DIV_W-1:0] div_reg_q, div_reg_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] phase_q, phase_d;
  logic [WIDTH-1:0] tri_val_q, tri_val_d;
  dir_e             dir_q, dir_d;
  mode_e            mode_q, mode_d;
  logic             ld_q_q, ld_q_d;
  logic [WIDTH-1:0] r2r_q, r2r_d;
  logic             tick_q, tick_d;
  logic             sync_q, sync_d;

  logic load_edge, cnt_zero, mode_chg, upd;

  always_comb begin
    div_reg_d = div_reg_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    tri_val_d = tri_val_q;
    dir_d     = dir_q;
    mode_d    = mode_q;
    ld_q_d    = bus.load_divider;
    r2r_d     = r2r_q;
    tick_d    = 1'b0;
    sync_d    = 1'b0;

    load_edge = bus.load_divider & ~ld_q_q;
    cnt_zero  = (cnt_q == '0);
    mode_chg  = (mode_e'(bus.mode) != mode_q);
    // A load edge swallows a coinciding update; a mode change restarts the
    // waveform and holds r2r_out until the following update.
    upd       = cnt_zero & ~load_edge & ~mode_chg;

    if (load_edge) begin
      div_reg_d = bus.div_in;
      cnt_d     = bus.div_in;
    end else if (cnt_zero) begin
      cnt_d = div_reg_q;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end

    if (mode_chg) begin
      mode_d    = mode_e'(bus.mode);
      phase_d   = '0;
      tri_val_d = '0;
      dir_d     = DIR_UP;
    end else if (upd) begin
      tick_d = 1'b1;
      if (bus.ext_data) begin
        r2r_d = bus.data;
      end else begin
        unique case (mode_q)
          MODE_RAMP_UP: r2r_d = phase_q;
          MODE_RAMP_DN: r2r_d = ~phase_q;
          MODE_TRI:     r2r_d = tri_val_q;
          MODE_SQUARE:  r2r_d = {WIDTH{phase_q[WIDTH-1]}};
          default:      r2r_d = phase_q;
        endcase
        sync_d  = (phase_q == '0);
        phase_d = phase_q + 1'b1;
        // Turn around at the endpoints so they are emitted only once.
        if (dir_q == DIR_UP) begin
          if (tri_val_q == '1) begin
            tri_val_d = tri_val_q - 1'b1;
            dir_d     = DIR_DOWN;
          end else begin
            tri_val_d = tri_val_q + 1'b1;
          end
        end else begin
          if (tri_val_q == '0) begin
            tri_val_d = tri_val_q + 1'b1;
            dir_d     = DIR_UP;
          end else begin
            tri_val_d = tri_val_q - 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_reg_q <= DIV_W'(DIV_RESET);
      cnt_q     <= DIV_W'(DIV_RESET);
      phase_q   <= '0;
      tri_val_q <= '0;
      dir_q     <= DIR_UP;
      mode_q    <= MODE_RAMP_UP;
      ld_q_q    <= 1'b0;
      r2r_q     <= '0;
      tick_q    <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      div_reg_q <= div_reg_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      tri_val_q <= tri_val_d;
      dir_q     <= dir_d;
      mode_q    <= mode_d;
      ld_q_q    <= ld_q_d;
      r2r_q     <= r2r_d;
      tick_q    <= tick_d;
      sync_q    <= sync_d;
    end
  end

  assign bus.r2r_out = r2r_q;
  assign bus.tick    = tick_q;
  assign bus.sync    = sync_q;

endmodule

// File: tb/tb_r2r_dac_wavegen.sv
// Bench for r2r_dac_wavegen: directed scenarios followed by randomized
// traffic, all compared against a reference model that derives the
// waveform from the count of updates since the last restart.
module tb_r2r_dac_wavegen;
  localparam int unsigned W     = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned NPH   = 1 << W;
  localparam int unsigned MAXV  = NPH - 1;

  logic clk;
  logic rst;

  r2r_dac_wavegen_if #(.WIDTH(W), .DIV_W(DW)) bus ();

  r2r_dac_wavegen #(.WIDTH(W), .DIV_W(DW), .DIV_RESET(9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned vectors;
  int unsigned miscompares;

  // Reference model state
  int unsigned m_div;    // update period minus one
  int unsigned m_since;  // clocks since the divider last restarted
  bit          m_ldq;
  int unsigned m_mode;
  int unsigned m_k;      // updates since the waveform restarted
  int unsigned m_out;
  bit          m_tick;
  bit          m_sync;

  function automatic int unsigned wave(input int unsigned md, input int unsigned k);
    int unsigned p;
    case (md)
      0: return k % NPH;
      1: return MAXV - (k % NPH);
      2: begin
        p = k % (2 * MAXV);
        return (p <= MAXV) ? p : (2 * MAXV - p);
      end
      default: return (((k / (NPH / 2)) % 2) != 0) ? MAXV : 0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_div = 9; m_since = 0; m_ldq = 0; m_mode = 0; m_k = 0;
    m_out = 0; m_tick = 0; m_sync = 0;
  endtask

  task automatic step();
    bit ld_edge, upd, mchg;
    @(posedge clk);
    ld_edge = bus.load_divider && !m_ldq;
    upd     = (m_since == m_div) && !ld_edge;
    mchg    = (int'(bus.mode) != m_mode);
    m_ldq   = bus.load_divider;
    if (ld_edge) begin
      m_div = bus.div_in; m_since = 0;
    end else if (m_since == m_div) m_since = 0;
    else m_since++;
    m_tick = upd && !mchg;
    m_sync = 0;
    if (mchg) begin
      m_mode = bus.mode; m_k = 0;
    end else if (upd) begin
      if (bus.ext_data) m_out = bus.data;
      else begin
        m_out  = wave(m_mode, m_k);
        m_sync = (m_k % NPH) == 0;
        m_k++;
      end
    end
    #1;
    check("r2r_out", 32'(bus.r2r_out), m_out);
    check("tick",    32'(bus.tick),    32'(m_tick));
    check("sync",    32'(bus.sync),    32'(m_sync));
  endtask

  task automatic steps(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  task automatic step_to_tick(input string tag);
    bit seen;
    seen = 0;
    for (int unsigned i = 0; i < 40 && !seen; i++) begin
      step();
      seen = bus.tick;
    end
    check({tag, "_tick_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic load_div(input int unsigned v);
    bus.load_divider = 1'b1;
    bus.div_in       = DW'(v);
    step();
    bus.load_divider = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    bus.ext_data = 0; bus.mode = 2'b00; bus.data = '0;
    bus.load_divider = 0; bus.div_in = '0;
    model_reset();

    // 1: reset and first ticks at the reset divider
    rst = 1'b1;
    #2;
    check("rst_out",  32'(bus.r2r_out), 32'd0);
    check("rst_tick", 32'(bus.tick),    32'd0);
    check("rst_sync", 32'(bus.sync),    32'd0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();
    steps(9);
    step();
    check("t1_first_tick", 32'(bus.tick), 32'd1);
    check("t1_first_out",  32'(bus.r2r_out), 32'd0);
    check("t1_first_sync", 32'(bus.sync), 32'd1);
    steps(9);
    step();
    check("t1_second_tick", 32'(bus.tick), 32'd1);
    check("t1_second_out",  32'(bus.r2r_out), 32'd1);
    check("t1_second_sync", 32'(bus.sync), 32'd0);

    // 2: full-rate ramps
    load_div(0);
    steps(36);
    bus.mode = 2'b01;
    steps(36);

    // 3: triangle, one step per 2 clocks
    load_div(1);
    bus.mode = 2'b10;
    steps(70);

    // 4: square at full rate, mode switch mid-level
    load_div(0);
    bus.mode = 2'b11;
    steps(37);
    bus.mode = 2'b00;
    steps(5);
    bus.mode = 2'b11;
    steps(20);

    // 5: external data, invisible between updates, then resume
    bus.mode = 2'b00;
    load_div(3);
    steps(6);
    bus.ext_data = 1'b1; bus.data = 4'hA;
    step_to_tick("t5a");
    check("t5_ext_out", 32'(bus.r2r_out), 32'hA);
    bus.data = 4'h5;
    steps(2);
    bus.data = 4'hA;
    step_to_tick("t5b");
    check("t5_hidden_out", 32'(bus.r2r_out), 32'hA);
    bus.ext_data = 1'b0;
    steps(20);

    // 6: mid-count load, held load, async reset mid-triangle
    load_div(7);
    steps(3);
    bus.load_divider = 1'b1; bus.div_in = 8'd3;
    step();
    steps(3);
    check("t6_pre_tick", 32'(bus.tick), 32'd0);
    step();
    check("t6_load_tick", 32'(bus.tick), 32'd1);
    steps(20);
    bus.load_divider = 1'b0;
    bus.mode = 2'b10;
    load_div(0);
    steps(22);
    rst = 1'b1;
    #1;
    check("t6_async_out", 32'(bus.r2r_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    load_div(0);
    steps(40);

    // Randomized traffic
    for (int unsigned i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 29) == 0) bus.mode = 2'($urandom);
      if ($urandom_range(0, 19) == 0) bus.ext_data = ~bus.ext_data;
      bus.data = W'($urandom);
      if ($urandom_range(0, 14) == 0) begin
        bus.load_divider = ~bus.load_divider;
        bus.div_in = DW'($urandom_range(0, 3));
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
